piano_note_sequencer: RTL
=========================

// Module: piano_note_sequencer
// PURPOSE
//  Controller sequencing the scale ROM (8-bit ASCII address -> 24-bit tone period, 0 = unmapped key).
//  Arbitrates two requesters, a keyboard byte stream (valid/ready) and an autoplay scan of the ROM.
//  Each hit drives the tone generator with a timed note followed by a silent gap.
//  Sits between the UART RX FIFO and the square-wave tone generator in the piano top level.
// PARAMETERS
//  NOTE_CYCLES      25_000_000   reset note length in clk cycles
//  GAP_CYCLES        1_250_000   silent cycles after every note (>=1)
//  MIN_NOTE_CYCLES   1_000_000   floor for speed-up halving
//  MAX_NOTE_CYCLES 100_000_000   ceiling for slow-down doubling
//  LEN_W            27           width of note-length register/counter (holds MAX_NOTE_CYCLES)
// PORTS
//  clk             in   1   system clock
//  rst_n           in   1   asynchronous active-low reset
//  key_data        in   8   ASCII byte from RX FIFO
//  key_valid       in   1   key_data valid
//  key_ready       out  1   byte consumed on key_valid & key_ready
//  autoplay_start  in   1   1-cycle pulse: begin ROM scan
//  abort           in   1   1-cycle pulse: stop current note/scan
//  speed_up        in   1   1-cycle pulse: halve note length
//  speed_down      in   1   1-cycle pulse: double note length
//  rom_address     out  8   registered ROM address
//  rom_data        in   24  combinational ROM output for rom_address
//  rom_last_addr   in   8   last valid ROM address
//  tone_period     out  24  period to tone generator; 0 = silent
//  tone_active     out  1   high while a note sounds
//  busy            out  1   state != IDLE
//  key_miss        out  1   1-cycle pulse: keyboard byte mapped to 0
// BEHAVIOUR
//  Reset (async, immediate): state IDLE; tone_period 0, tone_active 0, rom_address 0, key_miss 0,
//   busy 0, note_len = NOTE_CYCLES, scan flag 0. key_ready = 1 in IDLE after reset.
//  key_ready = (state==IDLE) & ~autoplay_start (combinational). autoplay_start beats key_valid in same cycle.
//  States: IDLE, FETCH, PLAY, GAP.
//  IDLE: key handshake -> rom_address<=key_data, scan<=0, FETCH. autoplay_start -> rom_address<=0, scan<=1, FETCH.
//  FETCH (1 cycle, samples rom_data):
//   data!=0 -> tone_period<=data, tone_active<=1, counter<=note_len, PLAY.
//   data==0 & ~scan -> key_miss pulse, IDLE.
//   data==0 & scan -> if rom_address==rom_last_addr: IDLE; else rom_address+1, stay FETCH.
//  PLAY: counter decrements; at 1 -> tone_period<=0, tone_active<=0, counter<=GAP_CYCLES, GAP.
//   Exactly note_len cycles of tone_active per note; key handshake cycle N -> tone_active rises at edge N+2.
//  GAP: counter decrements; at 1 -> scan & rom_address!=rom_last_addr: rom_address+1, FETCH; else IDLE.
//  abort in any non-IDLE state: next edge IDLE, tone_period 0, tone_active 0, scan 0; ignored in IDLE.
//  note_len: speed_up -> max(note_len>>1, MIN_NOTE_CYCLES); speed_down -> min(note_len<<1, MAX_NOTE_CYCLES);
//   both same cycle -> unchanged; any state; takes effect at next PLAY load, never mid-note.
//  rom_address never wraps: scan ends at rom_last_addr, including rom_last_addr=255.
//  rom_data treated as unsigned 24-bit; no arithmetic on it.
// STRUCTURE
//  piano_seq_defs.vh: state encoding localparams, default timing constants.
//  Sub-module piano_note_timer: LEN_W down-counter with load, value, done=(count==1)&running,
//   reused for PLAY and GAP.
//  FSM, note_len register and address logic in top.
// TESTING (bench: NOTE_CYCLES=8, GAP_CYCLES=2, MIN=2, MAX=32, LEN_W=6; real scale ROM attached)
//  1 key 'z'(122) valid at cycle N -> key_ready=1 at N; tone_period=477781, tone_active=1 for 8 cycles from N+2;
//    then 2 silent cycles; then IDLE.
//  2 key 'a'(97, ROM=0) -> key_miss pulse 1 cycle, tone_active never high, IDLE after FETCH.
//  3 autoplay_start, rom_last_addr=40 -> notes 100441, 84461, 67036 in order (addrs 35, 37, 38);
//    key_ready=0 throughout; IDLE after addr 40.
//  4 autoplay_start and key_valid same cycle -> scan starts; key not consumed until IDLE.
//  5 speed_up x3 -> note_len 4, 2, 2 (floor); speed_down x5 -> 4, 8, 16, 32, 32 (ceiling);
//    pulse during PLAY leaves current note length intact.
//  6 abort mid-PLAY, and rst_n low mid-GAP -> outputs zero (abort: next edge; reset: immediately);
//    next key plays normally.

Source files
------------

// File: rtl/piano_note_sequencer_pkg.sv
// Shared types and default timing constants for the piano note sequencer.
package piano_note_sequencer_pkg;

    // Sequencer states
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StPlay,
        StGap
    } seq_state_e;

    // Default timing, in clk cycles
    localparam int unsigned DefNoteCycles    = 25_000_000;
    localparam int unsigned DefGapCycles     = 1_250_000;
    localparam int unsigned DefMinNoteCycles = 1_000_000;
    localparam int unsigned DefMaxNoteCycles = 100_000_000;
    localparam int unsigned DefLenW          = 27;

    // ROM geometry
    localparam int unsigned AddrW   = 8;
    localparam int unsigned PeriodW = 24;

endpackage

// File: rtl/piano_note_timer.sv
// Down-counter with load; done is high on the last counted cycle while running.
// Shared by the note and gap phases of the sequencer.
module piano_note_timer #(
    parameter int unsigned LEN_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [LEN_W-1:0] load_value,
    input  logic             clear,
    output logic             done
);

    logic [LEN_W-1:0] count_q, count_d;
    logic             running_q, running_d;

    // Counter and running flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    // Next count: clear beats load, load beats decrement; stops itself after reaching 1
    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        if (clear) begin
            count_d   = '0;
            running_d = 1'b0;
        end else if (load) begin
            count_d   = load_value;
            running_d = (load_value != '0);
        end else if (running_q) begin
            if (count_q == LEN_W'(1)) begin
                count_d   = '0;
                running_d = 1'b0;
            end else begin
                count_d = count_q - LEN_W'(1);
            end
        end
    end

    assign done = running_q & (count_q == LEN_W'(1));

endmodule

// File: rtl/piano_note_sequencer.sv
// Note sequencer: arbitrates keyboard bytes and an autoplay ROM scan, looks up the
// tone period in the scale ROM and drives the tone generator with a timed note and gap.
module piano_note_sequencer
    import piano_note_sequencer_pkg::*;
#(
    parameter int unsigned NOTE_CYCLES     = DefNoteCycles,
    parameter int unsigned GAP_CYCLES      = DefGapCycles,
    parameter int unsigned MIN_NOTE_CYCLES = DefMinNoteCycles,
    parameter int unsigned MAX_NOTE_CYCLES = DefMaxNoteCycles,
    parameter int unsigned LEN_W           = DefLenW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [AddrW-1:0]   key_data,
    input  logic               key_valid,
    output logic               key_ready,
    input  logic               autoplay_start,
    input  logic               abort,
    input  logic               speed_up,
    input  logic               speed_down,
    output logic [AddrW-1:0]   rom_address,
    input  logic [PeriodW-1:0] rom_data,
    input  logic [AddrW-1:0]   rom_last_addr,
    output logic [PeriodW-1:0] tone_period,
    output logic               tone_active,
    output logic               busy,
    output logic               key_miss
);

    localparam logic [LEN_W-1:0] NoteLenRst = LEN_W'(NOTE_CYCLES);
    localparam logic [LEN_W-1:0] GapLen     = LEN_W'(GAP_CYCLES);
    localparam logic [LEN_W-1:0] MinLen     = LEN_W'(MIN_NOTE_CYCLES);
    localparam logic [LEN_W-1:0] MaxLen     = LEN_W'(MAX_NOTE_CYCLES);

    seq_state_e         state_q, state_d;
    logic [AddrW-1:0]   rom_address_q, rom_address_d;
    logic [PeriodW-1:0] tone_period_q, tone_period_d;
    logic               tone_active_q, tone_active_d;
    logic               key_miss_q, key_miss_d;
    logic               scan_q, scan_d;
    logic [LEN_W-1:0]   note_len_q, note_len_d;

    logic               timer_load;
    logic               timer_clear;
    logic [LEN_W-1:0]   timer_value;
    logic               timer_done;

    logic [LEN_W-1:0]   halved;
    logic [LEN_W:0]     doubled;

    assign key_ready   = (state_q == StIdle) & ~autoplay_start;
    assign busy        = (state_q != StIdle);
    assign rom_address = rom_address_q;
    assign tone_period = tone_period_q;
    assign tone_active = tone_active_q;
    assign key_miss    = key_miss_q;

    piano_note_timer #(
        .LEN_W (LEN_W)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_value),
        .clear      (timer_clear),
        .done       (timer_done)
    );

    // FSM and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rom_address_q <= '0;
            tone_period_q <= '0;
            tone_active_q <= 1'b0;
            key_miss_q    <= 1'b0;
            scan_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            rom_address_q <= rom_address_d;
            tone_period_q <= tone_period_d;
            tone_active_q <= tone_active_d;
            key_miss_q    <= key_miss_d;
            scan_q        <= scan_d;
        end
    end

    // Next state, ROM address and tone outputs; abort overrides everything outside IDLE
    always_comb begin
        state_d       = state_q;
        rom_address_d = rom_address_q;
        tone_period_d = tone_period_q;
        tone_active_d = tone_active_q;
        key_miss_d    = 1'b0;
        scan_d        = scan_q;
        timer_load    = 1'b0;
        timer_clear   = 1'b0;
        timer_value   = note_len_q;

        case (state_q)
            StIdle: begin
                // autoplay_start wins over a waiting key (key_ready is low that cycle)
                if (autoplay_start) begin
                    rom_address_d = '0;
                    scan_d        = 1'b1;
                    state_d       = StFetch;
                end else if (key_valid) begin
                    rom_address_d = key_data;
                    scan_d        = 1'b0;
                    state_d       = StFetch;
                end
            end
            StFetch: begin
                if (rom_data != '0) begin
                    tone_period_d = rom_data;
                    tone_active_d = 1'b1;
                    timer_load    = 1'b1;
                    timer_value   = note_len_q;
                    state_d       = StPlay;
                end else if (!scan_q) begin
                    key_miss_d = 1'b1;
                    state_d    = StIdle;
                end else if (rom_address_q == rom_last_addr) begin
                    scan_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    rom_address_d = rom_address_q + AddrW'(1);
                end
            end
            StPlay: begin
                if (timer_done) begin
                    tone_period_d = '0;
                    tone_active_d = 1'b0;
                    timer_load    = 1'b1;
                    timer_value   = GapLen;
                    state_d       = StGap;
                end
            end
            StGap: begin
                if (timer_done) begin
                    // Scan stops at rom_last_addr, so the address never wraps
                    if (scan_q && (rom_address_q != rom_last_addr)) begin
                        rom_address_d = rom_address_q + AddrW'(1);
                        state_d       = StFetch;
                    end else begin
                        scan_d  = 1'b0;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (abort && (state_q != StIdle)) begin
            state_d       = StIdle;
            tone_period_d = '0;
            tone_active_d = 1'b0;
            scan_d        = 1'b0;
            key_miss_d    = 1'b0;
            timer_load    = 1'b0;
            timer_clear   = 1'b1;
        end
    end

    assign halved  = note_len_q >> 1;
    assign doubled = {note_len_q, 1'b0};

    // Note length register; only read when a note is loaded, so changes never cut a note
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note_len_q <= NoteLenRst;
        end else begin
            note_len_q <= note_len_d;
        end
    end

    // Saturating halve/double; simultaneous requests cancel
    always_comb begin
        note_len_d = note_len_q;
        if (speed_up && !speed_down) begin
            note_len_d = (halved < MinLen) ? MinLen : halved;
        end else if (speed_down && !speed_up) begin
            note_len_d = (doubled > {1'b0, MaxLen}) ? MaxLen : doubled[LEN_W-1:0];
        end
    end

endmodule
